// File: rtl/sram_write_arbiter_pkg.sv
// Shared SRAM write-channel definitions: widths, arbiter state and grant encodings.
// Used by the write arbiter, the SRAM controller and the SystemACE bridge.
package sram_write_arbiter_pkg;

    localparam int SRAM_AW = 21;
    localparam int SRAM_DW = 32;
    localparam int STAT_W  = 16;

    typedef enum logic [2:0] {
        ARB_IDLE = 3'b001,
        ARB_G0   = 3'b010,
        ARB_G1   = 3'b100
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            ARB_G0:  return GRANT_0;
            ARB_G1:  return GRANT_1;
            default: return GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sram_arb_stat_counter.sv
// Saturating accepted-write counter with synchronous clear; clear beats increment.
module sram_arb_stat_counter
    import sram_write_arbiter_pkg::*;
(
    input  logic              CLK80,
    input  logic              RST,
    input  logic              clear_i,
    input  logic              inc_i,
    output logic [STAT_W-1:0] count_o
);

    localparam logic [STAT_W-1:0] COUNT_MAX = '1;
    localparam logic [STAT_W-1:0] COUNT_ONE = STAT_W'(1);

    logic [STAT_W-1:0] count_q;

    always_ff @(posedge CLK80 or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != COUNT_MAX)) begin
            count_q <= count_q + COUNT_ONE;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/sram_write_arbiter.sv
// Round-robin, burst-based arbiter sharing the SRAM write port between two requesters,
// with idle-timeout release and a per-requester lock. Data path is a zero-latency mux.
module sram_write_arbiter
    import sram_write_arbiter_pkg::*;
#(
    parameter int BURST_LEN    = 64,
    parameter int IDLE_TIMEOUT = 4
)
(
    input  logic               CLK80,
    input  logic               RST,
    input  logic [SRAM_AW-1:0] req0_address,
    input  logic [SRAM_DW-1:0] req0_data,
    input  logic               req0_we,
    input  logic               req0_lock,
    output logic               req0_full,
    input  logic [SRAM_AW-1:0] req1_address,
    input  logic [SRAM_DW-1:0] req1_data,
    input  logic               req1_we,
    input  logic               req1_lock,
    output logic               req1_full,
    output logic [SRAM_AW-1:0] data_w_address,
    output logic [SRAM_DW-1:0] data_w,
    output logic               data_w_we,
    input  logic               data_w_full,
    output logic [1:0]         grant,
    input  logic               stats_clear,
    output logic [STAT_W-1:0]  wr_count0,
    output logic [STAT_W-1:0]  wr_count1
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);
    localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TIMEOUT - 1);
    localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

    arb_state_t    state_q;
    logic          last_owner_q;
    logic [BW-1:0] burst_q;
    logic [IW-1:0] idle_q;

    logic own_idx;
    logic own_we;
    logic own_lock;
    logic other_we;
    logic granted;
    logic accept;
    logic rel_now;

    always_comb begin
        own_we         = 1'b0;
        own_lock       = 1'b0;
        other_we       = 1'b0;
        data_w_address = '0;
        data_w         = '0;
        data_w_we      = 1'b0;
        req0_full      = 1'b1;
        req1_full      = 1'b1;
        case (state_q)
            ARB_G0: begin
                own_we         = req0_we;
                own_lock       = req0_lock;
                other_we       = req1_we;
                data_w_address = req0_address;
                data_w         = req0_data;
                data_w_we      = req0_we;
                req0_full      = data_w_full;
            end
            ARB_G1: begin
                own_we         = req1_we;
                own_lock       = req1_lock;
                other_we       = req0_we;
                data_w_address = req1_address;
                data_w         = req1_data;
                data_w_we      = req1_we;
                req1_full      = data_w_full;
            end
            default: ;
        endcase
    end

    assign own_idx = (state_q == ARB_G1);
    assign granted = (state_q == ARB_G0) || (state_q == ARB_G1);
    assign accept  = data_w_we && !data_w_full;
    // Counters saturate at their limit, so an equality test also covers counts that
    // ran past the limit while the owner held its lock.
    assign rel_now = granted && !own_lock &&
                     ((accept && (burst_q == BURST_MAX)) || (!own_we && (idle_q == IDLE_MAX)));
    assign grant   = grant_of(state_q);

    always_ff @(posedge CLK80 or negedge RST) begin
        if (!RST) begin
            state_q      <= ARB_IDLE;
            last_owner_q <= 1'b1;
            burst_q      <= '0;
            idle_q       <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    burst_q <= '0;
                    idle_q  <= '0;
                    if (req0_we && (!req1_we || last_owner_q)) begin
                        state_q <= ARB_G0;
                    end else if (req1_we) begin
                        state_q <= ARB_G1;
                    end
                end
                ARB_G0, ARB_G1: begin
                    if (rel_now) begin
                        last_owner_q <= own_idx;
                        burst_q      <= '0;
                        idle_q       <= '0;
                        if (other_we) begin
                            state_q <= own_idx ? ARB_G0 : ARB_G1;
                        end else if (!own_we) begin
                            state_q <= ARB_IDLE;
                        end
                    end else begin
                        if (accept && (burst_q != BURST_MAX)) begin
                            burst_q <= burst_q + BURST_ONE;
                        end
                        if (own_we) begin
                            idle_q <= '0;
                        end else if (idle_q != IDLE_MAX) begin
                            idle_q <= idle_q + IDLE_ONE;
                        end
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    sram_arb_stat_counter u_count0 (
        .CLK80   (CLK80),
        .RST     (RST),
        .clear_i (stats_clear),
        .inc_i   (accept && !own_idx),
        .count_o (wr_count0)
    );

    sram_arb_stat_counter u_count1 (
        .CLK80   (CLK80),
        .RST     (RST),
        .clear_i (stats_clear),
        .inc_i   (accept && own_idx),
        .count_o (wr_count1)
    );

endmodule

// File: tb/tb_sram_write_arbiter.sv
// Self-checking bench for sram_write_arbiter: per-requester scoreboards, a vector table
// for the idle-timeout handover and hand-written sequences for the multi-cycle cases.
module tb_sram_write_arbiter;

    logic        CLK80;
    logic        RST;
    logic [20:0] req0_address, req1_address;
    logic [31:0] req0_data, req1_data;
    logic        req0_we, req1_we, req0_lock, req1_lock;
    logic        req0_full, req1_full;
    logic [20:0] data_w_address;
    logic [31:0] data_w;
    logic        data_w_we, data_w_full;
    logic [1:0]  grant;
    logic        stats_clear;
    logic [15:0] wr_count0, wr_count1;

    sram_write_arbiter #(.BURST_LEN(4), .IDLE_TIMEOUT(4)) dut (
        .CLK80          (CLK80),
        .RST            (RST),
        .req0_address   (req0_address),
        .req0_data      (req0_data),
        .req0_we        (req0_we),
        .req0_lock      (req0_lock),
        .req0_full      (req0_full),
        .req1_address   (req1_address),
        .req1_data      (req1_data),
        .req1_we        (req1_we),
        .req1_lock      (req1_lock),
        .req1_full      (req1_full),
        .data_w_address (data_w_address),
        .data_w         (data_w),
        .data_w_we      (data_w_we),
        .data_w_full    (data_w_full),
        .grant          (grant),
        .stats_clear    (stats_clear),
        .wr_count0      (wr_count0),
        .wr_count1      (wr_count1)
    );

    initial CLK80 = 1'b0;
    always #5 CLK80 = ~CLK80;

    typedef struct {
        logic [20:0] a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        bit       we0, we1, lock0, full;
        bit [1:0] gnt;
        bit       dwe, f0, f1;
    } vec_t;

    localparam bit H = 1'b1;
    localparam bit L = 1'b0;

    wr_t  q0[$];
    wr_t  q1[$];
    int   acc_log[$];
    int   errors = 0;
    int   checks = 0;
    int   idx0 = 0, idx1 = 0;
    bit   pend0 = 1'b0, pend1 = 1'b0;
    logic acc0_seen = 1'b0, acc1_seen = 1'b0;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] addr_of(input int src, input int i);
        return {src[0], 4'hA, i[15:0]};
    endfunction

    function automatic logic [31:0] data_of(input int src, input int i);
        return {(src != 0) ? 16'hB11B : 16'hC0DE, i[15:0]};
    endfunction

    // A requester holds we, address and data until its write is accepted.
    task automatic drive(input bit w0, input bit w1, input bit l0, input bit l1, input bit f);
        if (w0 && !pend0) begin
            pend0 = 1'b1;
            q0.push_back('{addr_of(0, idx0), data_of(0, idx0)});
        end
        if (w1 && !pend1) begin
            pend1 = 1'b1;
            q1.push_back('{addr_of(1, idx1), data_of(1, idx1)});
        end
        req0_we      = pend0;
        req1_we      = pend1;
        req0_address = addr_of(0, idx0);
        req0_data    = data_of(0, idx0);
        req1_address = addr_of(1, idx1);
        req1_data    = data_of(1, idx1);
        req0_lock    = l0;
        req1_lock    = l1;
        data_w_full  = f;
    endtask

    task automatic next_cycle();
        @(posedge CLK80);
        if (acc0_seen) begin
            pend0 = 1'b0;
            idx0++;
        end
        if (acc1_seen) begin
            pend1 = 1'b0;
            idx1++;
        end
        #1;
    endtask

    task automatic clear_model();
        q0.delete();
        q1.delete();
        acc_log.delete();
        idx0  = 0;
        idx1  = 0;
        pend0 = 1'b0;
        pend1 = 1'b0;
    endtask

    task automatic do_reset();
        RST         = 1'b0;
        stats_clear = 1'b0;
        clear_model();
        drive(L, L, L, L, L);
        @(posedge CLK80);
        #1;
        clear_model();
        RST = 1'b1;
    endtask

    // Scoreboard: every accepted write must match the oldest outstanding one of its owner.
    always @(negedge CLK80) begin
        acc0_seen <= RST && req0_we && !req0_full;
        acc1_seen <= RST && req1_we && !req1_full;
        if (RST && data_w_we && !data_w_full) begin
            wr_t exp_w;
            int  src;
            src = (grant == 2'b10) ? 1 : 0;
            if (grant != 2'b01 && grant != 2'b10) begin
                chk("accept_without_grant", {30'd0, grant}, 32'd1);
            end else if ((src == 0 && q0.size() == 0) || (src == 1 && q1.size() == 0)) begin
                chk("scoreboard_underflow", 32'(src), 32'hFFFF_FFFF);
            end else begin
                exp_w = (src == 0) ? q0.pop_front() : q1.pop_front();
                chk("sb_address", {11'd0, data_w_address}, {11'd0, exp_w.a});
                chk("sb_data", data_w, exp_w.d);
                acc_log.push_back(src);
            end
        end
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int cyc;
        int bad_g, bad_f, bad_f1, gaps;
        bit fullv;

        // idle-timeout handover: we0, we1, lock0, full -> grant, data_w_we, req0_full, req1_full
        tbl[0] = '{H, L, L, L, 2'b00, L, H, H};
        tbl[1] = '{H, L, L, L, 2'b01, H, L, H};
        tbl[2] = '{H, L, L, L, 2'b01, H, L, H};
        tbl[3] = '{L, H, L, L, 2'b01, L, L, H};
        tbl[4] = '{L, H, L, L, 2'b01, L, L, H};
        tbl[5] = '{L, H, L, L, 2'b01, L, L, H};
        tbl[6] = '{L, H, L, L, 2'b01, L, L, H};
        tbl[7] = '{L, H, L, L, 2'b10, H, H, L};
        tbl[8] = '{L, H, L, H, 2'b10, H, H, H};

        // Reset state
        RST         = 1'b0;
        stats_clear = 1'b0;
        drive(L, L, L, L, L);
        @(posedge CLK80);
        #4;
        chk("rst_grant", grant, 2'b00);
        chk("rst_dwe", data_w_we, 1'b0);
        chk("rst_req0_full", req0_full, 1'b1);
        chk("rst_req1_full", req1_full, 1'b1);
        chk("rst_address", data_w_address, 21'd0);
        chk("rst_data", data_w, 32'd0);
        chk("rst_wr_count0", wr_count0, 16'd0);
        chk("rst_wr_count1", wr_count1, 16'd0);
        @(posedge CLK80);
        #1;
        RST = 1'b1;

        // Single requester streams 10 writes
        drive(H, L, L, L, L);
        #3;
        chk("s1_grant_idle", grant, 2'b00);
        next_cycle();
        drive(H, L, L, L, L);
        #3;
        chk("s1_grant_next", grant, 2'b01);
        next_cycle();
        cyc   = 0;
        bad_g = 0;
        while (idx0 < 10 && cyc < 100) begin
            drive(idx0 < 9 || !pend0 ? (idx0 < 10) : H, L, L, L, L);
            #3;
            if (grant != 2'b01) bad_g++;
            next_cycle();
            cyc++;
        end
        drive(L, L, L, L, L);
        #3;
        chk("s1_writes_done", idx0, 10);
        chk("s1_grant_steady", bad_g, 0);
        chk("s1_wr_count0", wr_count0, 16'd10);
        chk("s1_wr_count1", wr_count1, 16'd0);
        chk("s1_queue_drained", q0.size(), 0);

        // Burst limit: both stream, ownership alternates every 4 acceptances
        next_cycle();
        do_reset();
        cyc  = 0;
        gaps = 0;
        while (acc_log.size() < 24 && cyc < 100) begin
            drive(H, H, L, L, L);
            #3;
            if (acc_log.size() > 0 && !data_w_we) gaps++;
            next_cycle();
            cyc++;
        end
        chk("s2_acceptances", acc_log.size(), 24);
        chk("s2_no_gaps", gaps, 0);
        for (int k = 0; k < 24 && k < acc_log.size(); k++) begin
            chk($sformatf("s2_owner_%0d", k), acc_log[k], (k / 4) % 2);
        end

        // Idle timeout, table driven
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].we0, tbl[i].we1, tbl[i].lock0, L, tbl[i].full);
            #3;
            chk($sformatf("s3_grant_%0d", i), grant, tbl[i].gnt);
            chk($sformatf("s3_dwe_%0d", i), data_w_we, tbl[i].dwe);
            chk($sformatf("s3_req0_full_%0d", i), req0_full, tbl[i].f0);
            chk($sformatf("s3_req1_full_%0d", i), req1_full, tbl[i].f1);
            next_cycle();
        end
        chk("s3_wr_count0", wr_count0, 16'd2);
        chk("s3_wr_count1", wr_count1, 16'd1);

        // Lock with pulsing backpressure: req0 keeps the grant for 20 writes
        do_reset();
        cyc    = 0;
        bad_g  = 0;
        bad_f  = 0;
        bad_f1 = 0;
        while (idx0 < 20 && cyc < 200) begin
            fullv = (cyc % 2 == 0);
            drive(H, H, H, L, fullv);
            #3;
            if (cyc > 0) begin
                if (grant != 2'b01) bad_g++;
                if (req0_full !== data_w_full) bad_f++;
            end
            if (req1_full !== 1'b1) bad_f1++;
            next_cycle();
            cyc++;
        end
        chk("s4_writes_done", idx0, 20);
        chk("s4_grant_held", bad_g, 0);
        chk("s4_req0_full_mirror", bad_f, 0);
        chk("s4_req1_full_high", bad_f1, 0);
        chk("s4_wr_count0", wr_count0, 16'd20);
        chk("s4_wr_count1", wr_count1, 16'd0);
        for (int i = 0; i < 4; i++) begin
            drive(L, H, L, L, L);
            next_cycle();
        end
        drive(L, H, L, L, L);
        #3;
        chk("s4_handover", grant, 2'b10);

        // Counter saturation and clear priority
        do_reset();
        cyc = 0;
        while (idx1 < 70000 && cyc < 75000) begin
            drive(L, H, L, L, L);
            next_cycle();
            cyc++;
        end
        drive(L, H, L, L, L);
        #3;
        chk("s5_saturated", wr_count1, 16'hFFFF);
        chk("s5_accepting", data_w_we && !data_w_full, 1'b1);
        stats_clear = 1'b1;
        next_cycle();
        stats_clear = 1'b0;
        drive(L, H, L, L, L);
        #3;
        chk("s5_clear_wins", wr_count1, 16'd0);
        next_cycle();
        drive(L, H, L, L, L);
        #3;
        chk("s5_count_resumes", wr_count1, 16'd1);
        chk("s5_wr_count0", wr_count0, 16'd0);

        // Reset in the middle of a req1 burst
        next_cycle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(L, H, L, L, L);
            next_cycle();
        end
        drive(L, H, L, L, L);
        #2;
        chk("s6_pre_grant", grant, 2'b10);
        RST = 1'b0;
        #1;
        chk("s6_grant", grant, 2'b00);
        chk("s6_dwe", data_w_we, 1'b0);
        chk("s6_req0_full", req0_full, 1'b1);
        chk("s6_req1_full", req1_full, 1'b1);
        chk("s6_wr_count1", wr_count1, 16'd0);
        @(posedge CLK80);
        #1;
        clear_model();
        RST = 1'b1;
        drive(H, H, L, L, L);
        #3;
        chk("s6_idle_after", grant, 2'b00);
        next_cycle();
        drive(H, H, L, L, L);
        #3;
        chk("s6_req0_first", grant, 2'b01);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
